// File: rtl/f_regfile_issue_if.sv
// Issue/FPU handshake bundle between the decode/control side, the FPU and the FP register file.
// Latency: none; this is wiring only.
// Backpressure: issue_ready/issue_valid on the issue side, f_ready on the FPU completion side.
interface f_regfile_issue_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int FLAG_W = 5
);
    logic              issue_valid;
    logic              issue_ready;
    logic [AW-1:0]     issue_rd;
    logic [2:0]        issue_rm;
    logic [6:0]        issue_funct_7;
    logic [6:0]        funct_7;
    logic [2:0]        frm;
    logic              fpu_start;
    logic [DATA_W-1:0] FPU_out;
    logic [FLAG_W-1:0] flags;
    logic              f_ready;
    logic              busy;
    logic              illegal_rm;

    // Environment side: decode/control issuing ops and the FPU returning results.
    modport master (
        output issue_valid, issue_rd, issue_rm, issue_funct_7, FPU_out, flags, f_ready,
        input  issue_ready, funct_7, frm, fpu_start, busy, illegal_rm
    );

    // Register file / issue controller side.
    modport slave (
        input  issue_valid, issue_rd, issue_rm, issue_funct_7, FPU_out, flags, f_ready,
        output issue_ready, funct_7, frm, fpu_start, busy, illegal_rm
    );
endinterface

// File: rtl/f_regfile_issue.sv
// FP register file with FCSR (frm/fflags) and a single-outstanding FPU issue controller.
// Latency: fpu_start/illegal_rm one cycle after issue; writeback commits on the f_ready edge; reads combinational with bypass.
// Backpressure: issue_ready low while an op is outstanding; lw_stall refuses a load to the pending destination.
module f_regfile_issue #(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 32,
    parameter  int FLAG_W = 5,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              n_rst,
    f_regfile_issue_if.slave  io,
    input  logic [AW-1:0]     f_rs1,
    input  logic [AW-1:0]     f_rs2,
    output logic [DATA_W-1:0] f_rs1_data,
    output logic [DATA_W-1:0] f_rs2_data,
    input  logic              lw_en,
    input  logic [AW-1:0]     lw_rd,
    input  logic [DATA_W-1:0] lw_data,
    output logic              lw_stall,
    input  logic              csr_frm_we,
    input  logic              csr_fflags_we,
    input  logic [7:0]        csr_wdata,
    output logic [2:0]        f_frm_out,
    output logic [FLAG_W-1:0] f_flags
);
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [AW-1:0]     r_pending_rd;
    logic [6:0]        r_funct_7;
    logic [2:0]        r_frm;
    logic [2:0]        r_frm_csr;
    logic [FLAG_W-1:0] r_fflags;
    logic              r_fpu_start;
    logic              r_illegal_rm;
    logic              w_start_nxt;
    logic              w_illegal_nxt;
    logic [2:0]        w_rm_res;
    logic              w_rm_bad;
    logic              w_wb;
    logic              w_lw_wr;
    logic [FLAG_W-1:0] w_flags_acc;
    logic              w_unused_csr;

    // Dynamic rm (3'b111) takes the CSR value; 101/110/111 after resolution are reserved.
    assign w_rm_res = (io.issue_rm == 3'b111) ? r_frm_csr : io.issue_rm;
    assign w_rm_bad = (w_rm_res == 3'b101) || (w_rm_res == 3'b110) || (w_rm_res == 3'b111);

    // f_ready only counts while an op is outstanding; a stray completion in IDLE is dropped.
    assign w_wb        = io.f_ready && (r_state == S_BUSY);
    assign lw_stall    = lw_en && (r_state == S_BUSY) && (lw_rd == r_pending_rd);
    assign w_lw_wr     = lw_en && !lw_stall;
    assign w_flags_acc = w_wb ? io.flags : '0;

    assign io.issue_ready = (r_state == S_IDLE);
    assign io.busy        = (r_state == S_BUSY);
    assign io.fpu_start   = r_fpu_start;
    assign io.illegal_rm  = r_illegal_rm;
    assign io.funct_7     = r_funct_7;
    assign io.frm         = r_frm;
    assign f_frm_out      = r_frm_csr;
    assign f_flags        = r_fflags;
    assign w_unused_csr   = &{1'b0, csr_wdata[7:FLAG_W]};

    // Next-state and launch/reject pulse decode for the issue controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_start_nxt   = 1'b0;
        w_illegal_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io.issue_valid) begin
                    if (w_rm_bad) begin
                        w_illegal_nxt = 1'b1;
                    end else begin
                        w_start_nxt = 1'b1;
                        w_state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (io.f_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, one-cycle pulses, and op fields held stable for the whole BUSY period.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_fpu_start  <= 1'b0;
            r_illegal_rm <= 1'b0;
            r_pending_rd <= '0;
            r_funct_7    <= '0;
            r_frm        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fpu_start  <= w_start_nxt;
            r_illegal_rm <= w_illegal_nxt;
            if (w_start_nxt) begin
                r_pending_rd <= io.issue_rd;
                r_funct_7    <= io.issue_funct_7;
                r_frm        <= w_rm_res;
            end
        end
    end

    // Register array: load and FPU writeback never collide because a load to the pending rd stalls.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_lw_wr) begin
                r_regs[lw_rd] <= lw_data;
            end
            if (w_wb) begin
                r_regs[r_pending_rd] <= io.FPU_out;
            end
        end
    end

    // FCSR: a software fflags write still keeps flags accrued by a same-cycle completion.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_frm_csr <= '0;
            r_fflags  <= '0;
        end else begin
            if (csr_frm_we) begin
                r_frm_csr <= csr_wdata[2:0];
            end
            if (csr_fflags_we) begin
                r_fflags <= csr_wdata[FLAG_W-1:0] | w_flags_acc;
            end else begin
                r_fflags <= r_fflags | w_flags_acc;
            end
        end
    end

    // Read port 1 with bypass: FPU writeback beats an unstalled load, which beats the array.
    always_comb begin
        f_rs1_data = r_regs[f_rs1];
        if (w_lw_wr && (lw_rd == f_rs1)) begin
            f_rs1_data = lw_data;
        end
        if (w_wb && (r_pending_rd == f_rs1)) begin
            f_rs1_data = io.FPU_out;
        end
    end

    // Read port 2 with the same bypass priority.
    always_comb begin
        f_rs2_data = r_regs[f_rs2];
        if (w_lw_wr && (lw_rd == f_rs2)) begin
            f_rs2_data = lw_data;
        end
        if (w_wb && (r_pending_rd == f_rs2)) begin
            f_rs2_data = io.FPU_out;
        end
    end
endmodule

// File: tb/tb_f_regfile_issue.sv
// Directed bench for f_regfile_issue: reset, issue/complete, illegal rm, load stall, bypass, flags, mid-op reset.
// Latency: inputs driven 1ns after posedge, outputs checked ~1ns later, well away from the edge.
// Backpressure: FPU completion modelled by driving f_ready on chosen cycles.
module tb_f_regfile_issue;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int FLAG_W = 5;
    localparam int AW     = 5;

    logic              clk;
    logic              n_rst;
    logic [AW-1:0]     f_rs1;
    logic [AW-1:0]     f_rs2;
    logic [DATA_W-1:0] f_rs1_data;
    logic [DATA_W-1:0] f_rs2_data;
    logic              lw_en;
    logic [AW-1:0]     lw_rd;
    logic [DATA_W-1:0] lw_data;
    logic              lw_stall;
    logic              csr_frm_we;
    logic              csr_fflags_we;
    logic [7:0]        csr_wdata;
    logic [2:0]        f_frm_out;
    logic [FLAG_W-1:0] f_flags;

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;
    int n0;

    f_regfile_issue_if #(.DATA_W(DATA_W), .AW(AW), .FLAG_W(FLAG_W)) u_if ();

    f_regfile_issue #(.DATA_W(DATA_W), .NREGS(NREGS), .FLAG_W(FLAG_W)) u_dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .io            (u_if),
        .f_rs1         (f_rs1),
        .f_rs2         (f_rs2),
        .f_rs1_data    (f_rs1_data),
        .f_rs2_data    (f_rs2_data),
        .lw_en         (lw_en),
        .lw_rd         (lw_rd),
        .lw_data       (lw_data),
        .lw_stall      (lw_stall),
        .csr_frm_we    (csr_frm_we),
        .csr_fflags_we (csr_fflags_we),
        .csr_wdata     (csr_wdata),
        .f_frm_out     (f_frm_out),
        .f_flags       (f_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count launch pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (u_if.fpu_start === 1'b1) n_start++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst = 1'b0;
        f_rs1 = '0; f_rs2 = '0;
        lw_en = 1'b0; lw_rd = '0; lw_data = '0;
        csr_frm_we = 1'b0; csr_fflags_we = 1'b0; csr_wdata = '0;
        u_if.issue_valid = 1'b0; u_if.issue_rd = '0; u_if.issue_rm = '0; u_if.issue_funct_7 = '0;
        u_if.FPU_out = '0; u_if.flags = '0; u_if.f_ready = 1'b0;

        // 1. reset state
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        #1;
        check_eq("rst_frm_csr", 32'(f_frm_out), 32'd0);
        check_eq("rst_fflags", 32'(f_flags), 32'd0);
        check_eq("rst_issue_ready", 32'(u_if.issue_ready), 32'd1);
        check_eq("rst_busy", 32'(u_if.busy), 32'd0);
        check_eq("rst_fpu_start", 32'(u_if.fpu_start), 32'd0);
        check_eq("rst_illegal_rm", 32'(u_if.illegal_rm), 32'd0);
        for (int i = 0; i < NREGS; i++) begin
            f_rs1 = AW'(i);
            f_rs2 = AW'(NREGS - 1 - i);
            #1;
            check_eq("rst_reg_rs1", f_rs1_data, 32'd0);
            check_eq("rst_reg_rs2", f_rs2_data, 32'd0);
        end

        // 2. dynamic rm from CSR, 3-cycle FPU
        tick();
        csr_wdata = 8'h01; csr_frm_we = 1'b1;
        tick();
        csr_frm_we = 1'b0;
        #1 check_eq("csr_frm_wr", 32'(f_frm_out), 32'd1);
        n0 = n_start;
        u_if.issue_valid = 1'b1; u_if.issue_rd = 5'd5; u_if.issue_rm = 3'b111; u_if.issue_funct_7 = 7'h00;
        tick();
        u_if.issue_valid = 1'b0;
        #1;
        check_eq("t2_start", 32'(u_if.fpu_start), 32'd1);
        check_eq("t2_busy", 32'(u_if.busy), 32'd1);
        check_eq("t2_ready_lo", 32'(u_if.issue_ready), 32'd0);
        check_eq("t2_frm", 32'(u_if.frm), 32'd1);
        tick();
        check_eq("t2_start_pulse_end", 32'(u_if.fpu_start), 32'd0);
        check_eq("t2_frm_held", 32'(u_if.frm), 32'd1);
        tick();
        tick();
        u_if.f_ready = 1'b1; u_if.FPU_out = 32'h3F800000; u_if.flags = 5'b00001; f_rs1 = 5'd5;
        #1 check_eq("t2_wb_bypass", f_rs1_data, 32'h3F800000);
        tick();
        u_if.f_ready = 1'b0; u_if.flags = '0;
        #1;
        check_eq("t2_idle", 32'(u_if.busy), 32'd0);
        check_eq("t2_ready", 32'(u_if.issue_ready), 32'd1);
        check_eq("t2_fflags", 32'(f_flags), 32'd1);
        check_eq("t2_reg5", f_rs1_data, 32'h3F800000);
        check_eq("t2_start_count", 32'(n_start - n0), 32'd1);

        // 3. illegal resolved rm, then a legal static rm
        csr_wdata = 8'h05; csr_frm_we = 1'b1;
        tick();
        csr_frm_we = 1'b0;
        n0 = n_start;
        u_if.issue_valid = 1'b1; u_if.issue_rd = 5'd1; u_if.issue_rm = 3'b111;
        tick();
        u_if.issue_valid = 1'b0;
        #1;
        check_eq("t3_illegal", 32'(u_if.illegal_rm), 32'd1);
        check_eq("t3_no_start", 32'(u_if.fpu_start), 32'd0);
        check_eq("t3_idle", 32'(u_if.issue_ready), 32'd1);
        tick();
        check_eq("t3_illegal_pulse_end", 32'(u_if.illegal_rm), 32'd0);
        check_eq("t3_start_count", 32'(n_start - n0), 32'd0);
        u_if.issue_valid = 1'b1; u_if.issue_rd = 5'd7; u_if.issue_rm = 3'b010; u_if.issue_funct_7 = 7'h15;
        tick();
        u_if.issue_valid = 1'b0;
        #1;
        check_eq("t3_start", 32'(u_if.fpu_start), 32'd1);
        check_eq("t3_frm", 32'(u_if.frm), 32'd2);
        check_eq("t3_funct", 32'(u_if.funct_7), 32'h15);

        // 4. load stall on pending rd, load to other rd with bypass
        lw_en = 1'b1; lw_rd = 5'd7; lw_data = 32'hAAAAAAAA; f_rs2 = 5'd7;
        #1;
        check_eq("t4_stall", 32'(lw_stall), 32'd1);
        check_eq("t4_stall_no_bypass", f_rs2_data, 32'd0);
        tick();
        lw_rd = 5'd3; lw_data = 32'hDEADBEEF; f_rs1 = 5'd3;
        #1;
        check_eq("t4_no_stall", 32'(lw_stall), 32'd0);
        check_eq("t4_lw_bypass", f_rs1_data, 32'hDEADBEEF);
        tick();
        lw_en = 1'b0;
        #1;
        check_eq("t4_reg3", f_rs1_data, 32'hDEADBEEF);
        check_eq("t4_reg7_unchanged", f_rs2_data, 32'd0);
        check_eq("t4_frm_held", 32'(u_if.frm), 32'd2);
        check_eq("t4_funct_held", 32'(u_if.funct_7), 32'h15);
        check_eq("t4_busy", 32'(u_if.busy), 32'd1);
        u_if.f_ready = 1'b1; u_if.FPU_out = 32'h11111111; u_if.flags = '0;
        tick();
        u_if.f_ready = 1'b0;
        #1 check_eq("t4_reg7", f_rs2_data, 32'h11111111);

        // 5. zero-latency completion, bypass, concurrent load, fflags write with accrual
        u_if.issue_valid = 1'b1; u_if.issue_rd = 5'd9; u_if.issue_rm = 3'b000; u_if.issue_funct_7 = 7'h01;
        tick();
        u_if.issue_valid = 1'b0;
        u_if.f_ready = 1'b1; u_if.FPU_out = 32'h40000000; u_if.flags = 5'b10000;
        csr_fflags_we = 1'b1; csr_wdata = 8'h00;
        f_rs2 = 5'd9; lw_en = 1'b1; lw_rd = 5'd4; lw_data = 32'h12345678; f_rs1 = 5'd4;
        #1;
        check_eq("t5_start", 32'(u_if.fpu_start), 32'd1);
        check_eq("t5_wb_bypass", f_rs2_data, 32'h40000000);
        check_eq("t5_lw_bypass", f_rs1_data, 32'h12345678);
        check_eq("t5_no_stall", 32'(lw_stall), 32'd0);
        tick();
        u_if.f_ready = 1'b0; u_if.flags = '0; csr_fflags_we = 1'b0; lw_en = 1'b0;
        #1;
        check_eq("t5_fflags", 32'(f_flags), 32'h10);
        check_eq("t5_idle", 32'(u_if.busy), 32'd0);
        check_eq("t5_reg9", f_rs2_data, 32'h40000000);
        check_eq("t5_reg4", f_rs1_data, 32'h12345678);
        u_if.f_ready = 1'b1; u_if.FPU_out = 32'hFFFFFFFF; u_if.flags = 5'b01000;
        #1 check_eq("t5_idle_ready_no_bypass", f_rs2_data, 32'h40000000);
        tick();
        u_if.f_ready = 1'b0; u_if.flags = '0;
        #1;
        check_eq("t5_idle_ready_flags", 32'(f_flags), 32'h10);
        check_eq("t5_idle_ready_reg9", f_rs2_data, 32'h40000000);

        // 6. reset during BUSY drops the pending op
        u_if.issue_valid = 1'b1; u_if.issue_rd = 5'd10; u_if.issue_rm = 3'b000;
        tick();
        u_if.issue_valid = 1'b0;
        #1 check_eq("t6_busy", 32'(u_if.busy), 32'd1);
        n_rst = 1'b0;
        #2;
        check_eq("t6_rst_busy", 32'(u_if.busy), 32'd0);
        check_eq("t6_rst_start", 32'(u_if.fpu_start), 32'd0);
        n_rst = 1'b1;
        tick();
        u_if.f_ready = 1'b1; u_if.FPU_out = 32'hCAFEF00D; u_if.flags = 5'b11111; f_rs1 = 5'd10;
        #1 check_eq("t6_no_bypass", f_rs1_data, 32'd0);
        tick();
        u_if.f_ready = 1'b0; u_if.flags = '0;
        #1;
        check_eq("t6_reg10", f_rs1_data, 32'd0);
        check_eq("t6_reg9_cleared", f_rs2_data, 32'd0);
        check_eq("t6_fflags", 32'(f_flags), 32'd0);
        check_eq("t6_ready", 32'(u_if.issue_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/f_regfile_issue.md
Name: f_regfile_issue

Overview:
- Parametrised floating-point register file with an integrated FCSR (frm, fflags) and a single-outstanding FPU issue controller.
- Sits between decode/control and the FPU.
- Supplies operands and the resolved rounding mode, launches the operation, and waits for f_ready.
- On completion, writes FPU_out back and accrues exception flags; a separate load write port is arbitrated against the pending destination.

Parameters:
DATA_W, 32, operand/register width
NREGS, 32, number of FP registers
FLAG_W, 5, exception flag width (NV,DZ,OF,UF,NX, MSB..LSB)
AW, $clog2(NREGS), register address width (derived)

Ports:
clk  in  1  clock, all state on rising edge
n_rst  in  1  asynchronous active-low reset
f_rs1, f_rs2  in  AW  read addresses
f_rs1_data, f_rs2_data  out  DATA_W  read data (combinational, with bypass)
issue_valid  in  1  request to start FPU op
issue_ready  out  1  controller can accept issue
issue_rd  in  AW  destination register
issue_rm  in  3  instruction rm field (3'b111 = dynamic)
issue_funct_7  in  7  operation select
funct_7  out  7  latched op to FPU
frm  out  3  resolved rounding mode to FPU
fpu_start  out  1  one-cycle launch pulse
FPU_out  in  DATA_W  FPU result
flags  in  FLAG_W  FPU exception flags, valid with f_ready
f_ready  in  1  FPU completion
busy  out  1  op outstanding
illegal_rm  out  1  one-cycle pulse, issue rejected
lw_en  in  1  load write request (f_LW)
lw_rd  in  AW  load destination
lw_data  in  DATA_W  load data
lw_stall  out  1  load write refused this cycle
csr_frm_we, csr_fflags_we  in  1  CSR writes
csr_wdata  in  8  CSR write data (frm=[2:0], fflags=[FLAG_W-1:0])
f_frm_out  out  3  current frm CSR
f_flags  out  FLAG_W  current fflags CSR

Behaviour:
- Reset (async, n_rst=0):
  - all registers, frm CSR, fflags, latched funct_7 and frm cleared to 0.
  - state=IDLE; fpu_start=0, busy=0, illegal_rm=0.
- States: IDLE, BUSY.
  - issue_ready = (state==IDLE).
  - busy = (state==BUSY).
- Issue: issue_valid && state==IDLE.
  - Resolve rm: issue_rm==3'b111 selects the frm CSR; otherwise issue_rm.
  - Resolved value 3'b101, 3'b110 or 3'b111: reject. Pulse illegal_rm next cycle, stay IDLE, no fpu_start.
  - Otherwise next cycle:
    - latch issue_rd as pending_rd, latch funct_7 and frm;
    - fpu_start=1 for exactly one cycle; state=BUSY.
  - frm and funct_7 are held stable for the whole BUSY period.
- BUSY, f_ready=1:
  - regs[pending_rd] <= FPU_out.
  - fflags <= fflags | flags.
  - state <= IDLE. A new issue is accepted the following cycle at earliest.
  - An f_ready that coincides with the fpu_start cycle is valid (zero-latency FPU).
  - f_ready while IDLE is ignored: no write, no flag accrual.
- Load port:
  - Stall: lw_stall = lw_en && busy && lw_rd==pending_rd. A stalled load does not write; the requester must hold.
  - Otherwise lw_en writes regs[lw_rd] <= lw_data.
  - Load and FPU writeback to different registers in the same cycle both commit.
- Read bypass, applied per port, in this priority:
  1. FPU writeback this cycle to the read address: return FPU_out.
  2. Else unstalled load write to the read address: return lw_data.
  3. Else array contents.
- CSR writes:
  - csr_frm_we: frm CSR <= csr_wdata[2:0]; takes effect for issues in the next cycle.
  - csr_fflags_we: fflags <= csr_wdata[FLAG_W-1:0] | (f_ready&&busy ? flags : 0). Accrual is never lost.
- Mid-operation reset: returns to IDLE and drops the pending op. A later f_ready is ignored.
- Flags are sticky; only a CSR write or reset clears them.

Test Plan:
1. Reset then read all addresses -> every register reads 0; f_frm_out=0, f_flags=0, issue_ready=1.
2. CSR frm=3'b001; issue rd=5, rm=3'b111, funct_7=7'h00. FPU returns f_ready 3 cycles later with FPU_out=32'h3F800000, flags=5'b00001 -> frm=3'b001 during BUSY; one fpu_start pulse; reg5=32'h3F800000; f_flags=5'b00001.
3. frm CSR=3'b101, issue rm=3'b111 -> illegal_rm pulses; no fpu_start; state stays IDLE. Issue with rm=3'b010 instead -> accepted with frm=3'b010.
4. While BUSY with pending_rd=7: lw_en to rd 7 -> lw_stall=1, reg7 unchanged. Same cycle, load to rd 3 with 32'hDEADBEEF -> written; reading rs1=3 that cycle returns 32'hDEADBEEF.
5. f_ready with FPU_out=32'h40000000 to rd 9 while rs2=9 -> f_rs2_data=32'h40000000 that cycle. Same cycle csr_fflags_we with data 0 and flags=5'b10000 -> f_flags=5'b10000.
6. Assert n_rst low mid-BUSY, release, then pulse f_ready -> no register write, flags stay 0, issue_ready=1.
